// File: rtl/dct_pkg.sv
// dct_pkg: shared widths, block size and state encoding for the butterfly stage
package dct_pkg;
    localparam int SAMPLE_W = 8;
    localparam int RES_W = SAMPLE_W + 1;
    localparam int N_PTS = 8;
    typedef enum logic [1:0] {LOAD, SUM, DIFF} state_t;
endpackage

// File: rtl/bfly_pair.sv
// bfly_pair: exact unsigned a+b (sel=0) or two's complement a-b (sel=1) at RW bits
module bfly_pair import dct_pkg::*; #(
    parameter int W = SAMPLE_W,
    parameter int RW = RES_W
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic          sel,
    output logic [RW-1:0] y
);
    assign y = sel ? RW'({1'b0, a}) - RW'({1'b0, b}) : RW'({1'b0, a}) + RW'({1'b0, b});
endmodule

// File: rtl/butterfly_seq.sv
// butterfly_seq: collects 8 samples, then emits x[k]+x[7-k] and x[k]-x[7-k] for k=0..3
// BUTTERFLY_DBLBUF_EN adds a ping-pong buffer so loading overlaps emission
module butterfly_seq #(
    parameter int SAMPLE_W = dct_pkg::SAMPLE_W,
    parameter int RES_W = dct_pkg::RES_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [RES_W-1:0]    R0,
    output logic [1:0]          Q,
    output logic                diff,
    output logic                out_valid,
    input  logic                out_ready
);
    import dct_pkg::*;

    state_t            r_state;
    logic [2:0]        r_widx;
    logic [1:0]        r_k;
    logic [RES_W-1:0]  r_r0;
    logic              r_diff;
    logic              r_out_valid;
    logic              w_acc;
    logic              w_fill;
    logic              w_xfer;
    logic              w_last;
    logic              w_start;
    logic              w_bypass;
    logic              w_nsel;
    logic [1:0]        w_nk;
    logic [SAMPLE_W-1:0] w_a;
    logic [SAMPLE_W-1:0] w_b;
    logic [RES_W-1:0]  w_res;

    assign w_acc = in_valid && in_ready;
    assign w_fill = w_acc && r_widx == 3'd7;
    assign w_xfer = r_out_valid && out_ready;
    assign w_last = w_xfer && r_state == DIFF && r_k == 2'd3;
    // next pair to present: k wraps 3->0 on its own, and the SUM->DIFF step flips sel
    assign w_nk = w_start ? 2'd0 : r_k + 2'd1;
    assign w_nsel = !w_start && (r_state == DIFF || r_k == 2'd3);

`ifdef BUTTERFLY_DBLBUF_EN
    logic [SAMPLE_W-1:0] r_buf [2*N_PTS];
    logic                r_wb;
    logic                r_rb;
    logic [1:0]          r_full;
    logic                w_nrb;

    assign in_ready = !r_full[r_wb];
    assign w_start = r_state == LOAD ? w_fill : w_last && (r_full[!r_rb] || w_fill);
    assign w_nrb = r_state == LOAD ? r_wb : r_rb ^ w_last;
    // x[7] of a block completing this very cycle is still on in_data, not yet in the buffer
    assign w_bypass = w_fill && w_nrb == r_wb;
    assign w_a = r_buf[{w_nrb, 1'b0, w_nk}];
    assign w_b = w_bypass ? in_data : r_buf[{w_nrb, 1'b1, ~w_nk}];

    always_ff @(posedge clk) begin
        if (w_acc) r_buf[{r_wb, r_widx}] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb <= 1'b0;
            r_rb <= 1'b0;
            r_full <= '0;
        end else begin
            r_rb <= w_nrb;
            if (w_fill) r_wb <= !r_wb;
            if (w_last) r_full[r_rb] <= 1'b0;
            if (w_fill) r_full[r_wb] <= 1'b1;
        end
    end
`else
    logic [SAMPLE_W-1:0] r_buf [N_PTS];

    assign in_ready = r_state == LOAD;
    assign w_start = w_fill;
    assign w_bypass = w_fill;
    assign w_a = r_buf[{1'b0, w_nk}];
    assign w_b = w_bypass ? in_data : r_buf[{1'b1, ~w_nk}];

    always_ff @(posedge clk) begin
        if (w_acc) r_buf[r_widx] <= in_data;
    end
`endif

    bfly_pair #(.W(SAMPLE_W), .RW(RES_W)) u_bfly (
        .a   (w_a),
        .b   (w_b),
        .sel (w_nsel),
        .y   (w_res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LOAD;
            r_widx <= '0;
            r_k <= '0;
            r_r0 <= '0;
            r_diff <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_acc) r_widx <= r_widx + 3'd1;
            if (w_start || (w_xfer && !w_last)) begin
                r_state <= w_nsel ? DIFF : SUM;
                r_k <= w_nk;
                r_r0 <= w_res;
                r_diff <= w_nsel;
                r_out_valid <= 1'b1;
            end else if (w_last) begin
                r_state <= LOAD;
                r_k <= '0;
                r_diff <= 1'b0;
                r_out_valid <= 1'b0;
            end
        end
    end

    assign R0 = r_r0;
    assign Q = r_k;
    assign diff = r_diff;
    assign out_valid = r_out_valid;
endmodule

// File: tb/tb_butterfly_seq.sv
// tb_butterfly_seq: directed and random blocks checked against an arithmetic reference queue
module tb_butterfly_seq;
    localparam int SW = 8;
    localparam int RW = 9;

    typedef struct packed {
        logic [RW-1:0] r0;
        logic [1:0]    q;
        logic          d;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [SW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready;
    logic [RW-1:0] R0;
    logic [1:0]    Q;
    logic          diff;
    logic          out_valid;

    int   checks = 0;
    int   errors = 0;
    int   run = 0;
    int   max_run = 0;
    res_t exp_q [$];
    res_t prev;
    res_t e_cur;
    logic prev_stall = 1'b0;
    logic [SW-1:0] xa [8];

    butterfly_seq #(.SAMPLE_W(SW), .RES_W(RW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .R0        (R0),
        .Q         (Q),
        .diff      (diff),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // reference: four pair sums, then four pair differences, wrapped to RW bits
    task automatic model(input logic [SW-1:0] x [8]);
        for (int j = 0; j < 8; j++) begin
            int k;
            int v;
            k = j % 4;
            v = (j < 4) ? int'(x[k]) + int'(x[7-k]) : int'(x[k]) - int'(x[7-k]);
            exp_q.push_back('{r0: RW'(v), q: 2'(k), d: (j >= 4)});
        end
    endtask

    // mode 0: in_valid held, 1: one idle cycle between samples, 2: random idle cycles
    task automatic send(input logic [SW-1:0] x [8], input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            if (mode == 1 && i > 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            if (mode == 2) repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data = x[i];
            while (!in_ready && t < 40) begin
                @(posedge clk); #1;
                t++;
            end
            if (t == 40) chk("in_ready_timeout", 32'(in_ready), 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (n == 8) begin
            model(x);
            chk("first_latency", 32'(out_valid), 1);
        end
    endtask

    task automatic drain(input bit rnd);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            t++;
        end
        out_ready = 1'b1;
        chk("drain", 32'(exp_q.size()), 0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            run = 0;
        end else begin
            if (prev_stall) chk("hold", {out_valid, diff, Q, R0}, {1'b1, prev.d, prev.q, prev.r0});
            run = out_valid ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", 32'(out_valid), 0);
                else begin
                    e_cur = exp_q.pop_front();
                    chk("r0", 32'(R0), 32'(e_cur.r0));
                    chk("q", 32'(Q), 32'(e_cur.q));
                    chk("diff", 32'(diff), 32'(e_cur.d));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev = '{r0: R0, q: Q, d: diff};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_r0", 32'(R0), 0);
        chk("rst_q", 32'(Q), 0);
        chk("rst_diff", 32'(diff), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 1);

        xa = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        send(xa, 8, 0);
        drain(0);
        chk("ready_after_block", 32'(in_ready), 1);

        xa = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        send(xa, 8, 0);
        drain(0);

        xa = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255};
        send(xa, 8, 0);
        drain(0);

        for (int i = 0; i < 8; i++) xa[i] = SW'($urandom);
        send(xa, 8, 0);
        @(posedge clk); #1;
        chk("stall_q_enter", 32'(Q), 1);
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_q", 32'(Q), 1);
            chk("stall_r0", 32'(R0), 32'(int'(xa[1]) + int'(xa[6])));
        end
        out_ready = 1'b1;
        drain(0);
        send(xa, 8, 1);
        drain(0);

        for (int i = 0; i < 8; i++) xa[i] = SW'($urandom);
        send(xa, 5, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midload_rst_valid", 32'(out_valid), 0);
        for (int i = 0; i < 8; i++) xa[i] = SW'($urandom);
        send(xa, 8, 0);
        drain(0);

        for (int i = 0; i < 8; i++) xa[i] = SW'($urandom);
        send(xa, 8, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midemit_rst_valid", 32'(out_valid), 0);
        chk("midemit_rst_ready", 32'(in_ready), 1);
        repeat (4) @(posedge clk);
        #1;
        chk("no_stale_out", 32'(out_valid), 0);

        max_run = 0;
        for (int i = 0; i < 8; i++) xa[i] = SW'($urandom);
        send(xa, 8, 0);
`ifdef BUTTERFLY_DBLBUF_EN
        for (int i = 0; i < 8; i++) xa[i] = SW'($urandom);
        send(xa, 8, 0);
        drain(0);
        chk("back_to_back_run", 32'(max_run), 16);
`else
        for (int i = 0; i < 8; i++) begin
            chk("emit_in_ready", 32'(in_ready), 0);
            @(posedge clk); #1;
        end
        chk("reload_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 8; i++) xa[i] = SW'($urandom);
        send(xa, 8, 0);
        drain(0);
        chk("block_run", 32'(max_run), 8);
`endif

        repeat (12) begin
            for (int i = 0; i < 8; i++) xa[i] = SW'($urandom);
            send(xa, 8, int'($urandom_range(0, 2)));
            drain(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/butterfly_seq.md
BUTTERFLY_SEQ -- requirements
Module: butterfly_seq

Interface
REQ-001 Parameter SAMPLE_W, default 8, unsigned input sample width.
REQ-002 Parameter RES_W, default 9, output result width; SHALL equal SAMPLE_W+1.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 in_data  input  SAMPLE_W  unsigned sample x[i], arriving in order i=0..7.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 R0  output  RES_W  butterfly result for the downstream two-register capture stage.
REQ-009 Q  output  2  pair index k of the current R0, 0..3.
REQ-010 diff  output  1  0: R0 is a sum; 1: R0 is a difference.
REQ-011 out_valid  output  1  R0/Q/diff are valid this cycle.
REQ-012 out_ready  input  1  downstream accepts the current result.

Function
REQ-013 A sample SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-014 States: LOAD (collect 8 samples), SUM (emit 4 sums), DIFF (emit 4 differences).
REQ-015 LOAD: in_ready=1, out_valid=0; a 3-bit write index increments per accepted sample; the 8th accept SHALL move to SUM on the next edge.
REQ-016 SUM: out_valid=1, diff=0, Q=k, R0 = x[k]+x[7-k], zero-extended to RES_W, exact (no overflow possible).
REQ-017 DIFF: out_valid=1, diff=1, Q=k, R0 = x[k]-x[7-k] as RES_W two's complement, exact.
REQ-018 k SHALL advance only on out_valid=1 and out_ready=1; when out_ready=0, R0, Q and diff SHALL hold.
REQ-019 k=3 transfer in SUM SHALL go to DIFF with k=0; k=3 transfer in DIFF SHALL return to LOAD with the write index at 0.
REQ-020 The first result SHALL appear one cycle after the 8th sample is accepted; with out_ready held at 1, the 8 results SHALL occupy 8 consecutive cycles.
REQ-021 R0/Q/diff SHALL be registered outputs; no combinational path from in_* to the out_* signals.
REQ-022 in_valid gaps during LOAD SHALL stall without losing or duplicating samples.

Reset
REQ-023 When rst_n=0 at a rising edge: state=LOAD, write index=0, k=0, R0=0, Q=0, diff=0, out_valid=0, and in_ready=1 from the following cycle.
REQ-024 Reset asserted mid-LOAD or mid-emit SHALL discard the partial block; no stale result SHALL be emitted after reset.
REQ-025 Sample buffer contents need not be cleared by reset.

Configuration
REQ-026 Macro BUTTERFLY_DBLBUF_EN: when defined, two sample buffers ping-pong; in_ready stays 1 during SUM/DIFF while the idle buffer is not full; a full idle buffer at the end of DIFF SHALL go straight to SUM with no bubble cycle.
REQ-027 Without BUTTERFLY_DBLBUF_EN: a single buffer; in_ready=0 throughout SUM and DIFF.

Structure
REQ-028 Package dct_pkg SHALL hold SAMPLE_W, RES_W, N_PTS=8, and the state enum (LOAD, SUM, DIFF).
REQ-029 Sub-module bfly_pair (combinational: a, b, sel -> a+b or a-b at RES_W) SHALL be the only arithmetic; one instance.

Verification
REQ-030 Reset, then x=10,20,30,40,50,60,70,80 with out_ready=1 -> sums (Q0..3) 90,90,90,90, then diffs -70,-50,-30,-10 (9-bit 0x1BA,0x1CE,0x1E2,0x1F6), then in_ready=1.
REQ-031 x all 255 -> sums 510 (0x1FE); diffs 0.
REQ-032 x=0,0,0,0,255,255,255,255 -> sum 255 ×4; diffs -255 (0x101) ×4.
REQ-033 out_ready=0 for 3 cycles at SUM k=1 -> R0=x1+x6 and Q=1 held, no result lost; in_valid toggled 1/0 during LOAD -> identical results.
REQ-034 rst_n=0 after the 5th sample, then a full new block -> results use only the new samples.
REQ-035 With BUTTERFLY_DBLBUF_EN, two back-to-back blocks, in_valid=1 and out_ready=1 throughout -> 16 consecutive results with no gap; without the macro, in_ready=0 for 8 cycles between blocks.
